// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: CPU load/store port to 8K x 32 RAM bridge (word-only RAM writes,
// registered RAM reads). Sub-word stores use read-modify-write.
// Ports: clk, rst (sync, active-high); cpu_req/we/size/addr/wdata in;
// cpu_rdata/ready/misalign out; mem_we/addr/din out, mem_dout in.
// Optional misalignment trap: define MEM_BUS_CTRL_ALIGN_CHK_EN.
module mem_bus_ctrl #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_size,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ready,
  output logic          cpu_misalign,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_din,
  input  logic [31:0]   mem_dout
);

  typedef enum logic [2:0] {
    IDLE, RD, MRG, WR, CAP, RESP
  } state_t;

  state_t      state;
  logic [AW+1:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [31:0] wbuf;
  logic        we_q;
  logic        mis_q;
  logic        misal;
  logic [31:0] merged;
  logic [31:0] rd_lane;

  always_comb begin
`ifdef MEM_BUS_CTRL_ALIGN_CHK_EN
    misal = (cpu_size == 2'b01 && cpu_addr[0]) ||
            (cpu_size[1] && cpu_addr[1:0] != 2'b00);
`else
    misal = 1'b0;
`endif
  end

  // Lane replacement of the old RAM word for sub-word stores.
  always_comb begin
    merged = mem_dout;
    case (size_q)
      2'b00: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01: merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // Right-aligned, zero-extended load data.
  always_comb begin
    rd_lane = mem_dout;
    case (size_q)
      2'b00: rd_lane = {24'h0, mem_dout[{addr_q[1:0], 3'b000} +: 8]};
      2'b01: rd_lane = {16'h0, mem_dout[{addr_q[1], 4'b0000} +: 16]};
      default: rd_lane = mem_dout;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wbuf      <= '0;
      we_q      <= 1'b0;
      mis_q     <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr[AW+1:0];
            size_q  <= cpu_size;
            wdata_q <= cpu_wdata;
            we_q    <= cpu_we;
            mis_q   <= misal;
            if (misal)
              state <= RESP;
            else if (cpu_we && cpu_size[1])
              state <= WR;
            else
              state <= RD;
          end
        end
        RD:   state <= we_q ? MRG : CAP;
        MRG: begin
          wbuf  <= merged;
          state <= WR;
        end
        WR:   state <= RESP;
        CAP: begin
          cpu_rdata <= rd_lane;
          state     <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register.
  assign mem_we       = (state == WR);
  assign cpu_ready    = (state == RESP);
  assign cpu_misalign = (state == RESP) && mis_q;
  assign mem_addr     = addr_q[AW+1:2];
  assign mem_din      = size_q[1] ? wdata_q : wbuf;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: bench for mem_bus_ctrl with a registered-read RAM
// model and a scoreboard of expected per-request results.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_misalign;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  mem_bus_ctrl #(.AW(13)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .cpu_misalign(cpu_misalign),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:8191];
  logic [31:0] ref_mem [0:8191];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    else mem_dout <= ram[mem_addr];
  end

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          we_at;
    logic [31:0] din;
    logic [12:0] waddr;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata = '0;

  function automatic logic [31:0] lane_get(logic [31:0] w, logic [1:0] sz,
                                           logic [1:0] a);
    int sh;
    sh = 8 * int'(a);
    case (sz)
      2'b00: return (w >> sh) & 32'h0000_00FF;
      2'b01: return a[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(logic [31:0] w, logic [1:0] sz,
                                        logic [1:0] a, logic [31:0] d);
    logic [31:0] m;
    m = w;
    case (sz)
      2'b00: m[8*int'(a) +: 8] = d[7:0];
      2'b01: m[16*int'(a[1]) +: 16] = d[15:0];
      default: m = d;
    endcase
    return m;
  endfunction

  function automatic bit is_mis(logic [1:0] sz, logic [1:0] a);
`ifdef MEM_BUS_CTRL_ALIGN_CHK_EN
    return (sz == 2'b01 && a[0]) || (sz[1] && a != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_req(input string nm, input logic we,
                         input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input bit hold);
    exp_t e;
    logic [12:0] wa;
    bit mis, done;
    int cyc, we_cnt, we_at;
    logic [31:0] din_seen;
    logic [12:0] addr1;
    wa = a[14:2];
    mis = is_mis(sz, a[1:0]);
    e.waddr = wa;
    e.mis = mis;
    e.din = '0;
    e.we_at = 0;
    if (mis) e.lat = 1;
    else if (we && sz[1]) begin
      e.lat = 2; e.we_at = 1; e.din = d;
    end else if (we) begin
      e.lat = 4; e.we_at = 3; e.din = merge(ref_mem[wa], sz, a[1:0], d);
    end else e.lat = 3;
    if (!mis && !we) last_rdata = lane_get(ref_mem[wa], sz, a[1:0]);
    if (e.we_at != 0) ref_mem[wa] = e.din;
    e.rdata = last_rdata;
    sb.push_back(e);

    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_size = sz;
    cpu_addr = a; cpu_wdata = d;
    @(posedge clk);
    #1;
    if (!hold) cpu_req = 1'b0;
    cyc = 1; we_cnt = 0; we_at = 0; din_seen = '0;
    addr1 = mem_addr; done = 1'b0;
    while (!done && cyc <= 20) begin
      if (mem_we) begin
        we_cnt++; we_at = cyc; din_seen = mem_din;
      end
      if (cpu_ready) begin
        done = 1'b1;
        cpu_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (cyc !== e.lat) begin
          errors++;
          $display("FAIL %s latency got %0d want %0d", nm, cyc, e.lat);
        end
        checks++;
        if (cpu_rdata !== e.rdata) begin
          errors++;
          $display("FAIL %s rdata got %h want %h", nm, cpu_rdata, e.rdata);
        end
        checks++;
        if (cpu_misalign !== e.mis) begin
          errors++;
          $display("FAIL %s misalign got %b want %b", nm, cpu_misalign, e.mis);
        end
        checks++;
        if (we_cnt !== (e.we_at != 0 ? 1 : 0) || we_at !== e.we_at) begin
          errors++;
          $display("FAIL %s mem_we count %0d at %0d want at %0d",
                   nm, we_cnt, we_at, e.we_at);
        end
        checks++;
        if (addr1 !== e.waddr) begin
          errors++;
          $display("FAIL %s mem_addr got %h want %h", nm, addr1, e.waddr);
        end
        if (e.we_at != 0) begin
          checks++;
          if (din_seen !== e.din) begin
            errors++;
            $display("FAIL %s mem_din got %h want %h", nm, din_seen, e.din);
          end
        end
      end else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      cpu_req = 1'b0;
      $display("FAIL %s timeout no cpu_ready got 0 want 1", nm);
      void'(sb.pop_front());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b10;
    cpu_addr = 32'h10; cpu_wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cpu_ready, cpu_misalign, mem_we} !== 3'b000 ||
        cpu_rdata !== 32'h0 || mem_addr !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs got rdy%b mis%b we%b rd%h a%h want all 0",
               cpu_ready, cpu_misalign, mem_we, cpu_rdata, mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    cpu_req = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (mem_we !== 1'b0 || cpu_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle got we%b rdy%b want 0 0", mem_we, cpu_ready);
      end
    end
    last_rdata = '0;
  endtask

  task automatic test_word_store;
    run_req("wstore_10", 1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_load_and_byte_store;
    run_req("wload_10", 1'b0, 2'b10, 32'h10, 32'h0, 1'b0);
    run_req("bstore_11", 1'b1, 2'b00, 32'h11, 32'h0000_00AA, 1'b0);
  endtask

  task automatic test_subword;
    run_req("hload_12", 1'b0, 2'b01, 32'h12, 32'h0, 1'b0);
    run_req("bload_13", 1'b0, 2'b00, 32'h13, 32'h0, 1'b0);
    run_req("wstore_7ffc", 1'b1, 2'b10, 32'h7FFC, 32'h1234_5678, 1'b0);
    run_req("bload_wrap", 1'b0, 2'b00, 32'h4003_FFFC, 32'h0, 1'b0);
    run_req("hstore_16", 1'b1, 2'b01, 32'h16, 32'h0000_BEEF, 1'b0);
    run_req("wload_14", 1'b0, 2'b10, 32'h14, 32'h0, 1'b0);
    run_req("bload_10", 1'b0, 2'b00, 32'h10, 32'h0, 1'b0);
    run_req("rsvd_size_ld", 1'b0, 2'b11, 32'h14, 32'h0, 1'b0);
  endtask

  task automatic test_misalign;
    run_req("wload_13", 1'b0, 2'b10, 32'h13, 32'h0, 1'b0);
    run_req("hstore_11", 1'b1, 2'b01, 32'h11, 32'h0000_1234, 1'b0);
    run_req("wload_10b", 1'b0, 2'b10, 32'h10, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_req("hold_store", 1'b1, 2'b10, 32'h20, 32'hCAFE_F00D, 1'b1);
    repeat (4) begin
      @(posedge clk);
      #1;
      checks++;
      if (mem_we !== 1'b0 || cpu_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_quiet got we%b rdy%b want 0 0", mem_we, cpu_ready);
      end
    end
    run_req("b2b_load", 1'b0, 2'b10, 32'h20, 32'h0, 1'b0);
    run_req("b2b_bstore", 1'b1, 2'b00, 32'h23, 32'h0000_0011, 1'b0);
    run_req("b2b_hload", 1'b0, 2'b01, 32'h22, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mrg;
    logic [31:0] saved;
    saved = ram[4];
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b00;
    cpu_addr = 32'h10; cpu_wdata = 32'h55;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_mrg_we got %b want 0", mem_we);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mem_we !== 1'b0 || cpu_ready !== 1'b0 || cpu_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mrg_state got we%b rdy%b rd%h want 0 0 0",
               mem_we, cpu_ready, cpu_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    last_rdata = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (mem_we !== 1'b0) begin
        errors++;
        $display("FAIL rst_mrg_nowrite got %b want 0", mem_we);
      end
    end
    checks++;
    if (ram[4] !== saved) begin
      errors++;
      $display("FAIL rst_mrg_ram got %h want %h", ram[4], saved);
    end
    run_req("post_rst_load", 1'b0, 2'b10, 32'h10, 32'h0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_word_store();
    test_load_and_byte_store();
    test_subword();
    test_misalign();
    test_back_to_back();
    test_reset_mrg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

endmodule
